// File: rtl/serial_logic_unit.sv
// Chunk-serial bitwise logic unit with start/busy/done handshake.
// Produces a registered result plus zero and parity status flags.
module serial_logic_unit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    function automatic logic [CHUNK-1:0] apply(
        input logic [2:0]       o,
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y
    );
        logic [CHUNK-1:0] r;
        r = '0;
        unique case (o)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: r = x ^ y;
            3'd3: r = ~(x ^ y);
            3'd4: r = ~(x & y);
            3'd5: r = ~(x | y);
            3'd6: r = x & ~y;
            3'd7: r = ~x;
        endcase
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;

    logic [CHUNK-1:0] a_c, b_c, r_c;
    logic [WIDTH-1:0] work_n;

    // One shared chunk operator; operands are muxed in by the chunk counter.
    always_comb begin
        a_c = '0;
        b_c = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) begin
                a_c = a_q[i*CHUNK +: CHUNK];
                b_c = b_q[i*CHUNK +: CHUNK];
            end
        end
        r_c    = apply(op_q, a_c, b_c);
        work_n = work_q;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) begin
                work_n[i*CHUNK +: CHUNK] = r_c;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        zero_d   = zero_q;
        parity_d = parity_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                work_d = work_n;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = work_n;
                    zero_d   = ~|work_n;
                    parity_d = ^work_n;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;
    assign parity = parity_q;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed bench for serial_logic_unit: 16/4 chunked instance and a
// 32/32 single-cycle instance sharing clock and reset.
module tb_serial_logic_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, zero, parity;
    logic [15:0] result;

    logic        start1 = 1'b0;
    logic [2:0]  op1 = '0;
    logic [31:0] a1 = '0;
    logic [31:0] b1 = '0;
    logic        busy1, done1, zero1, parity1;
    logic [31:0] result1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_logic_unit #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero),
        .parity(parity)
    );

    serial_logic_unit #(.WIDTH(32), .CHUNK(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(result1), .zero(zero1),
        .parity(parity1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] o,
                         input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] er, input logic ez,
                         input logic ep);
        int k;
        int bc;
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        k  = 0;
        bc = busy ? 1 : 0;
        while (!done && k < 20) begin
            tick();
            k++;
            if (busy) bc++;
        end
        chk({tag, "_lat"}, k, 4);
        chk({tag, "_busycyc"}, bc, 4);
        chk({tag, "_res"}, {16'h0, result}, {16'h0, er});
        chk({tag, "_zero"}, zero, ez);
        chk({tag, "_par"}, parity, ep);
        tick();
        chk({tag, "_donefall"}, done, 1'b0);
    endtask

    initial begin
        int k;
        int nd;
        int hold_bad;

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res", result, 0);
        chk("rst_zero", zero, 0);
        chk("rst_par", parity, 0);
        chk("rst_res1", result1, 0);
        rst_n = 1'b1;
        tick();

        do_op("xor", 3'd2, 16'hA5F0, 16'h0FF0, 16'hAA00, 1'b0, 1'b0);
        do_op("and", 3'd0, 16'h00FF, 16'hFF00, 16'h0000, 1'b1, 1'b0);
        do_op("nota", 3'd7, 16'h1234, 16'hFFFF, 16'hEDCB, 1'b0, 1'b1);
        do_op("nand", 3'd4, 16'hFF00, 16'h0F0F, 16'hF0FF, 1'b0, 1'b0);

        // Start while busy: second request must be dropped.
        op = 3'd1; a = 16'h000F; b = 16'h00F0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        op = 3'd0; a = 16'h0000; b = 16'h0000; start = 1'b1;
        tick();
        start = 1'b0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) nd++;
            tick();
        end
        chk("busy_start_dones", nd, 1);
        chk("busy_start_res", {16'h0, result}, 32'h00FF);

        // Back-to-back: restart in the done cycle.
        op = 3'd6; a = 16'hFFFF; b = 16'h0F0F; start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!done && k < 20) begin
            tick();
            k++;
        end
        chk("b2b_first_res", {16'h0, result}, 32'hF0F0);
        op = 3'd5; a = 16'h0000; b = 16'h0001; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy_rise", busy, 1);
        chk("b2b_done_drop", done, 0);
        k = 0;
        hold_bad = 0;
        while (!done && k < 20) begin
            if (result !== 16'hF0F0) hold_bad++;
            tick();
            k++;
        end
        chk("b2b_hold", hold_bad, 0);
        chk("b2b_lat", k, 4);
        chk("b2b_res", {16'h0, result}, 32'hFFFE);
        chk("b2b_par", parity, 1);
        tick();

        // Asynchronous reset in the middle of a run.
        op = 3'd2; a = 16'hFFFF; b = 16'h0000; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_res", result, 0);
        chk("arst_zero", zero, 0);
        chk("arst_par", parity, 0);
        #10;
        rst_n = 1'b1;
        tick();
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) nd++;
            tick();
        end
        chk("arst_no_spurious", nd, 0);
        do_op("post_rst", 3'd2, 16'h1234, 16'h00FF, 16'h12CB, 1'b0, 1'b1);

        // Single-cycle configuration.
        op1 = 3'd3; a1 = 32'hDEADBEEF; b1 = 32'hDEADBEEF; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("n1_busy", busy1, 1);
        chk("n1_done0", done1, 0);
        tick();
        chk("n1_busy_fall", busy1, 0);
        chk("n1_done", done1, 1);
        chk("n1_res", result1, 32'hFFFFFFFF);
        chk("n1_zero", zero1, 0);
        chk("n1_par", parity1, 0);
        tick();
        chk("n1_done_fall", done1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
